// File: rtl/rect_producer_pkg.sv
// Shared constants for the rectangle producer: default sizing and FSM state codes.
package rect_producer_pkg;

  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_W     = 4;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;
  localparam logic [1:0] SAMPLE   = 2'd3;

endpackage

// File: rtl/rect_fifo.sv
// Small synchronous FIFO with wrap-around pointers and show-ahead read data.
module rect_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          do_push, do_pop;

  // Push is gated only by occupancy before the edge, so push+pop on a full FIFO just pops.
  assign full    = (occ_q == FULL_OCC);
  assign empty   = (occ_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rect_producer.sv
// Producer side of the dav_/rfd handshake: buffers (a, b) pairs, hands them to the
// perimeter consumer one at a time, and accumulates the returned perimeters.
module rect_producer
  import rect_producer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned W     = DEF_W
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         dav_,
  input  logic         rfd,
  input  logic [W+1:0] p,
  output logic [W+5:0] total,
  output logic [7:0]   count,
  output logic         busy
);

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           dav_q, dav_d;
  logic [W+5:0]   total_q, total_d;
  logic [7:0]     count_q, count_d;
  logic           busy_q, busy_d;
  logic           pop;
  logic           full, empty;
  logic [2*W-1:0] head;
  logic [W+6:0]   sum;

  rect_fifo #(
    .DEPTH (DEPTH),
    .DW    (2 * W)
  ) u_fifo (
    .clock  (clock),
    .reset_ (reset_),
    .push   (in_valid),
    .pop    (pop),
    .wdata  ({in_a, in_b}),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  assign in_ready = ~full;
  assign sum      = (W+7)'(total_q) + (W+7)'(p);

  // Handshake sequencing, accumulator and transfer counter next-state logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dav_d   = dav_q;
    total_d = total_q;
    count_d = count_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && rfd) begin
          a_d     = head[2*W-1:W];
          b_d     = head[W-1:0];
          dav_d   = 1'b0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // The entry stays at the FIFO head until the consumer acknowledges it.
        if (!rfd) begin
          dav_d   = 1'b1;
          pop     = 1'b1;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (rfd) state_d = SAMPLE;
      end
      SAMPLE: begin
        total_d = sum[W+6] ? '1 : sum[W+5:0];
        count_d = count_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy is registered from the next state so it needs no decode after the flop.
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dav_q   <= 1'b1;
      total_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dav_q   <= dav_d;
      total_q <= total_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign dav_  = dav_q;
  assign total = total_q;
  assign count = count_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rect_producer.sv
// Self-checking bench for rect_producer with a behavioural perimeter consumer.
module tb_rect_producer;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int TMAX  = 1023;

  logic         clock    = 1'b0;
  logic         reset_   = 1'b0;
  logic [W-1:0] in_a     = '0;
  logic [W-1:0] in_b     = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         dav_;
  logic         rfd      = 1'b1;
  logic [W+1:0] p        = '0;
  logic [W+5:0] total;
  logic [7:0]   count;
  logic         busy;

  int n_checks = 0;
  int n_bad    = 0;
  int hold_err = 0;
  int tmo_err  = 0;
  logic auto_cons = 1'b0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] got_q[$];
  int model_total = 0;
  int model_count = 0;

  rect_producer #(.DEPTH(DEPTH), .W(W)) dut (
    .clock    (clock),
    .reset_   (reset_),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .dav_     (dav_),
    .rfd      (rfd),
    .p        (p),
    .total    (total),
    .count    (count),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: every delivered pair contributes its perimeter 2(a+b).
  task automatic model_push(input logic [W-1:0] ma, input logic [W-1:0] mb);
    exp_q.push_back({ma, mb});
    model_total = model_total + 2 * (int'(ma) + int'(mb));
    if (model_total > TMAX) model_total = TMAX;
    model_count = (model_count + 1) % 256;
  endtask

  task automatic model_clear();
    exp_q.delete();
    got_q.delete();
    model_total = 0;
    model_count = 0;
    hold_err = 0;
    tmo_err = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_ = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
    model_clear();
  endtask

  task automatic push_pair(input logic [W-1:0] pa, input logic [W-1:0] pb);
    int n = 0;
    while (!in_ready && n < 400) begin tick(); n++; end
    if (n >= 400) begin
      n_checks++; n_bad++;
      $display("FAIL push_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    in_a = pa; in_b = pb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    model_push(pa, pb);
  endtask

  task automatic wait_done(input int target, input int lim, output bit ok);
    int n = 0;
    while (got_q.size() < target && n < lim) begin tick(); n++; end
    ok = (got_q.size() >= target);
    repeat (10) tick();
  endtask

  // Behavioural consumer: random acknowledge/release delays, returns p = 2(a+b).
  initial begin
    logic [W-1:0] sa, sb;
    int d, n;
    forever begin
      tick();
      if (auto_cons && rfd && !dav_) begin
        sa = a; sb = b;
        d = $urandom_range(0, 2);
        repeat (d) begin tick(); if (a !== sa || b !== sb) hold_err++; end
        p = (W+2)'(2 * (int'(sa) + int'(sb)));
        rfd = 1'b0;
        got_q.push_back({sa, sb});
        n = 0;
        while (dav_ !== 1'b1 && n < 50) begin tick(); n++; if (a !== sa || b !== sb) hold_err++; end
        if (n >= 50) tmo_err++;
        d = $urandom_range(0, 2);
        repeat (d) begin tick(); if (a !== sa || b !== sb) hold_err++; end
        rfd = 1'b1;
        tick();
        if (a !== sa || b !== sb) hold_err++;
      end
    end
  end

  task automatic test_reset();
    auto_cons = 1'b0; rfd = 1'b1;
    do_reset();
    n_checks++; if (dav_ !== 1'b1)   begin n_bad++; $display("FAIL reset_dav: got %0b exp 1", dav_); end
    n_checks++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    n_checks++; if (total !== '0)    begin n_bad++; $display("FAIL reset_total: got %0d exp 0", total); end
    n_checks++; if (count !== '0)    begin n_bad++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
    n_checks++; if (a !== '0 || b !== '0) begin n_bad++; $display("FAIL reset_ab: got %0d,%0d exp 0,0", a, b); end
  endtask

  task automatic check_stream(input string name);
    bit ok;
    wait_done(exp_q.size(), 5000, ok);
    n_checks++; if (!ok || got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL %s_nxfer: got %0d exp %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL %s_pair%0d: got %0h exp %0h", name, i, got_q[i], exp_q[i]);
      end
    end
    n_checks++; if (total !== (W+6)'(model_total)) begin n_bad++; $display("FAIL %s_total: got %0d exp %0d", name, total, model_total); end
    n_checks++; if (count !== 8'(model_count)) begin n_bad++; $display("FAIL %s_count: got %0d exp %0d", name, count, model_count); end
    n_checks++; if (hold_err != 0) begin n_bad++; $display("FAIL %s_ab_hold: got %0d changes exp 0", name, hold_err); end
    n_checks++; if (tmo_err != 0) begin n_bad++; $display("FAIL %s_dav_timeout: got %0d exp 0", name, tmo_err); end
  endtask

  task automatic test_single();
    auto_cons = 1'b1;
    push_pair(4'd3, 4'd5);
    check_stream("single");
    n_checks++; if (total !== 10'd16) begin n_bad++; $display("FAIL single_total16: got %0d exp 16", total); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    auto_cons = 1'b0; rfd = 1'b1;
    push_pair(4'd7, 4'd9);
    push_pair(4'd2, 4'd2);
    while (dav_ !== 1'b0 && n < 20) begin tick(); n++; end
    n_checks++; if (busy !== 1'b1 || dav_ !== 1'b0) begin n_bad++; $display("FAIL mid_inflight: busy=%0b dav_=%0b exp 1,0", busy, dav_); end
    reset_ = 1'b0;
    tick();
    n_checks++; if (dav_ !== 1'b1) begin n_bad++; $display("FAIL mid_dav: got %0b exp 1", dav_); end
    n_checks++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %0b exp 0", busy); end
    n_checks++; if (total !== '0 || count !== '0) begin n_bad++; $display("FAIL mid_acc: got %0d/%0d exp 0/0", total, count); end
    n_checks++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_ready: got %0b exp 1", in_ready); end
    reset_ = 1'b1;
    model_clear();
    repeat (6) begin
      tick();
      n_checks++; if (dav_ !== 1'b1) begin n_bad++; $display("FAIL mid_fifo_empty: dav_=%0b exp 1", dav_); end
    end
  endtask

  task automatic test_burst();
    do_reset();
    auto_cons = 1'b1;
    push_pair(4'd1, 4'd1);
    push_pair(4'd2, 4'd3);
    push_pair(4'd4, 4'd4);
    push_pair(4'd15, 4'd15);
    check_stream("burst");
    n_checks++; if (total !== 10'd90) begin n_bad++; $display("FAIL burst_total90: got %0d exp 90", total); end
  endtask

  task automatic test_full();
    int occ = 0;
    auto_cons = 1'b0; rfd = 1'b0;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = 4'(i + 1); in_b = 4'(2 * i + 3);
      if (occ < DEPTH) begin model_push(in_a, in_b); occ++; end
      tick();
      n_checks++; if (in_ready !== (occ < DEPTH)) begin
        n_bad++; $display("FAIL full_in_ready%0d: got %0b exp %0b", i, in_ready, occ < DEPTH);
      end
    end
    in_valid = 1'b0;
    n_checks++; if (dav_ !== 1'b1) begin n_bad++; $display("FAIL full_no_start: dav_=%0b exp 1", dav_); end
    rfd = 1'b1; auto_cons = 1'b1;
    check_stream("full");
    repeat (30) tick();
    n_checks++; if (count !== 8'd4) begin n_bad++; $display("FAIL full_exact4: got %0d exp 4", count); end
  endtask

  task automatic test_saturation();
    do_reset();
    auto_cons = 1'b1;
    for (int i = 0; i < 18; i++) push_pair(4'd15, 4'd15);
    check_stream("sat");
    n_checks++; if (total !== 10'd1023) begin n_bad++; $display("FAIL sat_total1023: got %0d exp 1023", total); end
  endtask

  task automatic test_stall();
    int n = 0;
    auto_cons = 1'b0; rfd = 1'b1;
    do_reset();
    push_pair(4'd9, 4'd6);
    push_pair(4'd1, 4'd2);
    push_pair(4'd3, 4'd4);
    push_pair(4'd5, 4'd6);
    while (dav_ !== 1'b0 && n < 20) begin tick(); n++; end
    repeat (20) begin
      tick();
      n_checks++; if (dav_ !== 1'b0 || a !== 4'd9 || b !== 4'd6 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold: dav_=%0b a=%0d b=%0d in_ready=%0b exp 0,9,6,0", dav_, a, b, in_ready);
      end
    end
    p = 6'd30; rfd = 1'b0;
    got_q.push_back({a, b});
    tick();
    n_checks++; if (dav_ !== 1'b1) begin n_bad++; $display("FAIL stall_dav_rise: got %0b exp 1", dav_); end
    n_checks++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_pop: in_ready=%0b exp 1", in_ready); end
    repeat (20) begin
      tick();
      n_checks++; if (dav_ !== 1'b1 || busy !== 1'b1 || a !== 4'd9 || b !== 4'd6 || count !== 8'd0) begin
        n_bad++; $display("FAIL stall_rel: dav_=%0b busy=%0b a=%0d b=%0d count=%0d exp 1,1,9,6,0", dav_, busy, a, b, count);
      end
    end
    rfd = 1'b1;
    tick();
    n_checks++; if (count !== 8'd0 || a !== 4'd9 || b !== 4'd6) begin
      n_bad++; $display("FAIL stall_sample_wait: count=%0d a=%0d b=%0d exp 0,9,6", count, a, b);
    end
    tick();
    n_checks++; if (count !== 8'd1 || total !== 10'd30 || busy !== 1'b0) begin
      n_bad++; $display("FAIL stall_sample: count=%0d total=%0d busy=%0b exp 1,30,0", count, total, busy);
    end
    auto_cons = 1'b1;
    check_stream("stall");
  endtask

  task automatic test_random();
    do_reset();
    auto_cons = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 6)) tick();
      push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    check_stream("rand");
  endtask

  task automatic test_count_wrap();
    do_reset();
    auto_cons = 1'b1;
    for (int i = 0; i < 260; i++) push_pair(4'd0, 4'($urandom_range(0, 1)));
    check_stream("wrap");
    n_checks++; if (count !== 8'd4) begin n_bad++; $display("FAIL wrap_count4: got %0d exp 4", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_burst();
    test_full();
    test_saturation();
    test_stall();
    test_random();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
